// File: rtl/redundancy_selector_pkg.sv
// Shared definitions for the N-port redundant-link selector: FSM encoding,
// switch counter width and an elaboration-time log2 helper.
package redundancy_pkg;

    localparam logic [1:0] NONE    = 2'd0;
    localparam logic [1:0] ACTIVE  = 2'd1;
    localparam logic [1:0] PENDING = 2'd2;

    localparam int SWITCH_COUNT_W = 16;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/redundancy_selector_link_wtr.sv
// Per-port wait-to-restore qualifier: a port becomes usable only after its
// link_ok has been continuously high for WTR_CYCLES cycles.
module link_wtr
    import redundancy_pkg::*;
#(
    parameter int WTR_CYCLES = 125000
) (
    input  logic clk,
    input  logic rst,
    input  logic link_ok,
    output logic up_f
);

    localparam int CNT_W = (clog2(WTR_CYCLES + 1) < 1) ? 1 : clog2(WTR_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WTR_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WTR_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             up_q, up_d;

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        up_d  = up_q;
        if (!link_ok) begin
            cnt_d = '0;
            up_d  = 1'b0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
            up_d  = (cnt_q == CNT_LAST);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            up_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            up_q  <= up_d;
        end
    end

    assign up_f = up_q;

endmodule

// File: rtl/redundancy_selector.sv
// Chooses the active downstream port: immediate failover, WTR-guarded restore,
// optional revertive mode and management force; non-urgent moves wait for idle.
module redundancy_selector
    import redundancy_pkg::*;
#(
    parameter int NUM_PORTS  = 2,
    parameter int IDX_W      = 1,
    parameter int WTR_CYCLES = 125000,
    parameter int REVERTIVE  = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_PORTS-1:0]      link_ok,
    input  logic                      busy,
    input  logic                      force_en,
    input  logic [IDX_W-1:0]          force_sel,
    output logic [IDX_W-1:0]          sel,
    output logic [NUM_PORTS-1:0]      sel_onehot,
    output logic                      sel_valid,
    output logic                      all_down,
    output logic                      switch_pulse,
    output logic [SWITCH_COUNT_W-1:0] switch_count
);

    localparam int IDX_W_EXP = (clog2(NUM_PORTS) < 1) ? 1 : clog2(NUM_PORTS);

    if (IDX_W != IDX_W_EXP || NUM_PORTS < 2 || NUM_PORTS > 8) begin : g_bad_params
        $error("redundancy_selector: NUM_PORTS must be 2..8 and IDX_W max(1,clog2(NUM_PORTS))");
    end

    logic [NUM_PORTS-1:0] up_f;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        link_wtr #(.WTR_CYCLES(WTR_CYCLES)) u_wtr (
            .clk     (clk),
            .rst     (rst),
            .link_ok (link_ok[p]),
            .up_f    (up_f[p])
        );
    end

    logic [1:0]                state_q, state_d;
    logic [IDX_W-1:0]          sel_q, sel_d;
    logic [NUM_PORTS-1:0]      onehot_q, onehot_d;
    logic                      valid_q, all_down_q, pulse_q;
    logic [SWITCH_COUNT_W-1:0] count_q, count_d;

    logic [IDX_W-1:0] lowest, target;
    logic             any_up, force_hit, cur_up, commit;

    // Index compares instead of up_f[force_sel] keep out-of-range indices harmless.
    always_comb begin
        lowest    = '0;
        any_up    = 1'b0;
        force_hit = 1'b0;
        cur_up    = 1'b0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (up_f[i]) begin
                lowest = IDX_W'(i);
                any_up = 1'b1;
            end
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (up_f[i] && force_sel == IDX_W'(i)) force_hit = 1'b1;
            if (up_f[i] && sel_q == IDX_W'(i))     cur_up    = 1'b1;
        end
        target = lowest;
        if (force_en && force_hit) begin
            target = force_sel;
        end else if (REVERTIVE == 0 && cur_up) begin
            target = sel_q;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        commit  = 1'b0;
        case (state_q)
            NONE: begin
                if (any_up) commit = 1'b1;
            end
            ACTIVE: begin
                if (!any_up) begin
                    state_d = NONE;
                end else if (target != sel_q) begin
                    if (!cur_up || !busy) commit  = 1'b1;
                    else                  state_d = PENDING;
                end
            end
            PENDING: begin
                if (!any_up) begin
                    state_d = NONE;
                end else if (target == sel_q) begin
                    state_d = ACTIVE;
                end else if (!busy || !cur_up) begin
                    commit = 1'b1;
                end
            end
            default: state_d = NONE;
        endcase
        if (commit) begin
            sel_d   = target;
            state_d = ACTIVE;
        end
        count_d = (commit && count_q != '1) ? count_q + 1'b1 : count_q;
        for (int i = 0; i < NUM_PORTS; i++) begin
            onehot_d[i] = (state_d != NONE) && (sel_d == IDX_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= NONE;
            sel_q      <= '0;
            onehot_q   <= '0;
            valid_q    <= 1'b0;
            all_down_q <= 1'b1;
            pulse_q    <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            onehot_q   <= onehot_d;
            valid_q    <= (state_d != NONE);
            all_down_q <= (state_d == NONE);
            pulse_q    <= commit;
            count_q    <= count_d;
        end
    end

    assign sel          = sel_q;
    assign sel_onehot   = onehot_q;
    assign sel_valid    = valid_q;
    assign all_down     = all_down_q;
    assign switch_pulse = pulse_q;
    assign switch_count = count_q;

endmodule
